// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers:
//   PIPE_PAYLOAD_W  default payload width (instruction + PC + PC+4)
//   PIPE_NOP_INSN   canonical NOP instruction (addi x0, x0, 0)
//   PIPE_BUBBLE     full-width bubble payload carrying the NOP
//   occ_e           occupancy encoding of a stage (EMPTY / FULL / SKID)
//   occ_of()        maps the two entry valid bits onto occ_e
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_PAYLOAD_W = 96;

    localparam logic [31:0] PIPE_NOP_INSN = 32'h0000_0013;

    localparam logic [PIPE_PAYLOAD_W-1:0] PIPE_BUBBLE = {PIPE_NOP_INSN, 64'h0000_0000_0000_0000};

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_FULL  = 2'd1,
        OCC_SKID  = 2'd2
    } occ_e;

    // The skid entry is only ever valid while the main entry is valid,
    // so the two valid bits fully determine the stage state.
    function automatic occ_e occ_of(input logic main_v, input logic skid_v);
        occ_e occ;
        if (main_v && skid_v) begin
            occ = OCC_SKID;
        end else if (main_v) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_EMPTY;
        end
        return occ;
    endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// ---------------------------------------------------------------------------
// pipe_skid_entry
// One payload entry: a valid bit plus a DATA_W data register.
// Priority: clear > load > drop > hold.
//   clk, rst_n  clock, asynchronous active-low reset (valid=0, q=FLUSH_VAL)
//   clear       valid<=0, q<=FLUSH_VAL
//   load        valid<=1, q<=d
//   drop        valid<=0, q keeps its value (empty stage shows last data)
//   d           data to load
//   valid, q    registered entry contents
// ---------------------------------------------------------------------------
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_PAYLOAD_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic              drop,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    // Entry register: async reset, then clear/load/drop/hold in priority order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= FLUSH_VAL;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= FLUSH_VAL;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (drop) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
            q     <= q;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised pipeline stage register with valid/ready handshake,
// synchronous flush, external stall and optional two-entry skid buffer.
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                discard all held entries (wins over any transfer)
//   stall                acts exactly like out_ready=0
//   in_valid/in_ready    upstream handshake; in_data upstream payload
//   out_valid/out_ready  downstream handshake; out_data main entry payload
//   occupancy            registered count of held entries (0..2)
// SKID_EN=1: in_ready is registered (ready path broken between stages).
// SKID_EN=0: single entry, in_ready combinational from out_ready/stall.
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_PAYLOAD_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter bit                SKID_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v_s;
    logic [DATA_W-1:0] main_q_s;
    logic              skid_v_s;
    logic [DATA_W-1:0] skid_q_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;
    occ_e              state_s;
    occ_e              next_s;
    logic              main_load_s;
    logic              main_drop_s;
    logic [DATA_W-1:0] main_d_s;
    logic              skid_load_s;
    logic              skid_drop_s;
    // in_ready_r is 0 through reset; in no-skid mode it only gates in_ready
    // until the first edge after reset release.
    logic              in_ready_r;
    logic [1:0]        occ_r;

    assign out_fire_s = main_v_s & out_ready & ~stall;
    assign in_fire_s  = in_valid & in_ready_s;
    assign state_s    = occ_of(main_v_s, skid_v_s);

    pipe_skid_entry #(
        .DATA_W    (DATA_W),
        .FLUSH_VAL (FLUSH_VAL)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .load  (main_load_s),
        .drop  (main_drop_s),
        .d     (main_d_s),
        .valid (main_v_s),
        .q     (main_q_s)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_skid_entry #(
                .DATA_W    (DATA_W),
                .FLUSH_VAL (FLUSH_VAL)
            ) u_skid (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (flush),
                .load  (skid_load_s),
                .drop  (skid_drop_s),
                .d     (in_data),
                .valid (skid_v_s),
                .q     (skid_q_s)
            );
            assign in_ready_s = in_ready_r;
        end else begin : g_noskid
            assign skid_v_s   = 1'b0;
            assign skid_q_s   = FLUSH_VAL;
            assign in_ready_s = in_ready_r & (~main_v_s | (out_ready & ~stall));
        end
    endgenerate

    // Next-state and entry control; flush overrides every transfer.
    always_comb begin
        next_s      = state_s;
        main_load_s = 1'b0;
        main_drop_s = 1'b0;
        main_d_s    = in_data;
        skid_load_s = 1'b0;
        skid_drop_s = 1'b0;
        if (flush) begin
            next_s = OCC_EMPTY;
        end else begin
            case (state_s)
                OCC_EMPTY: begin
                    if (in_fire_s) begin
                        main_load_s = 1'b1;
                        next_s      = OCC_FULL;
                    end else begin
                        next_s = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (in_fire_s && out_fire_s) begin
                        main_load_s = 1'b1;
                        next_s      = OCC_FULL;
                    end else if (in_fire_s && SKID_EN) begin
                        skid_load_s = 1'b1;
                        next_s      = OCC_SKID;
                    end else if (out_fire_s) begin
                        main_drop_s = 1'b1;
                        next_s      = OCC_EMPTY;
                    end else begin
                        next_s = OCC_FULL;
                    end
                end
                OCC_SKID: begin
                    // in_ready is 0 here, so the skid entry simply moves up.
                    if (out_fire_s) begin
                        main_load_s = 1'b1;
                        main_d_s    = skid_q_s;
                        skid_drop_s = 1'b1;
                        next_s      = OCC_FULL;
                    end else begin
                        next_s = OCC_SKID;
                    end
                end
                default: begin
                    next_s = OCC_EMPTY;
                end
            endcase
        end
    end

    // Registered in_ready and occupancy, both derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            occ_r      <= 2'd0;
        end else begin
            in_ready_r <= (next_s != OCC_SKID);
            occ_r      <= next_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = main_v_s;
    assign out_data  = main_q_s;
    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances: u_skid (SKID_EN=1) and u_leg (SKID_EN=0, in_valid and
// out_ready tied high). A queue model tracks the skid instance and a plain
// flush/stall/load register tracks the legacy instance; both are compared
// on every falling edge. Directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         s_flush = 1'b0;
    logic         s_stall = 1'b0;
    logic         s_in_valid = 1'b0;
    logic         s_out_ready = 1'b0;
    logic [W-1:0] s_in_data = '0;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0]   s_occ;

    logic         l_flush = 1'b0;
    logic         l_stall = 1'b0;
    logic [W-1:0] l_in_data = '0;
    logic         l_in_ready;
    logic         l_out_valid;
    logic [W-1:0] l_out_data;
    logic [1:0]   l_occ;

    int n_chk  = 0;
    int n_pass = 0;

    // skid model state: held payloads in order, value shown when empty, ready
    logic [W-1:0] mq[$];
    logic [W-1:0] m_last = '0;
    logic         m_ready = 1'b0;
    // legacy model state
    logic [W-1:0] leg_q = '0;
    logic         leg_v = 1'b0;
    logic         leg_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W), .FLUSH_VAL({W{1'b0}}), .SKID_EN(1'b1)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .stall     (s_stall),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .occupancy (s_occ)
    );

    pipe_stage_reg #(.DATA_W(W), .FLUSH_VAL({W{1'b0}}), .SKID_EN(1'b0)) u_leg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (l_flush),
        .stall     (l_stall),
        .in_valid  (1'b1),
        .in_ready  (l_in_ready),
        .in_data   (l_in_data),
        .out_valid (l_out_valid),
        .out_ready (1'b1),
        .out_data  (l_out_data),
        .occupancy (l_occ)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare on the falling edge, then advance the models to the state they
    // must hold after the coming rising edge (inputs are stable until then).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                m_last  = '0;
                m_ready = 1'b0;
                leg_q   = '0;
                leg_v   = 1'b0;
            end
            check("skid_out_valid", 32'(s_out_valid), 32'(mq.size() > 0));
            check("skid_out_data", 32'(s_out_data), 32'(m_last));
            check("skid_occupancy", 32'(s_occ), 32'(mq.size()));
            check("skid_in_ready", 32'(s_in_ready), 32'(m_ready));
            if (leg_en) begin
                check("leg_out_data", 32'(l_out_data), 32'(leg_q));
                check("leg_out_valid", 32'(l_out_valid), 32'(leg_v));
                check("leg_occupancy", 32'(l_occ), 32'(leg_v));
            end
            if (rst_n) begin
                logic in_f;
                logic out_f;
                in_f  = s_in_valid && m_ready;
                out_f = (mq.size() > 0) && s_out_ready && !s_stall;
                if (s_flush) begin
                    mq.delete();
                    m_last = '0;
                end else begin
                    if (out_f) begin
                        void'(mq.pop_front());
                    end
                    if (in_f) begin
                        mq.push_back(s_in_data);
                    end
                    if (mq.size() > 0) begin
                        m_last = mq[0];
                    end
                end
                m_ready = (mq.size() < 2);
                if (l_flush) begin
                    leg_q = '0;
                    leg_v = 1'b0;
                end else if (!l_stall) begin
                    leg_q = l_in_data;
                    leg_v = 1'b1;
                end
            end
        end
    end

    initial begin
        logic prev_flush;
        // reset for three cycles, then release between edges
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        check("rst_in_ready_low", 32'(s_in_ready), 32'd0);
        check("rst_out_data", 32'(s_out_data), 32'd0);
        tick();
        check("rst_in_ready_high", 32'(s_in_ready), 32'd1);
        check("rst_occ", 32'(s_occ), 32'd0);

        // streaming 1..4 with out_ready high
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_in_data = W'(i);
            tick();
            check("stream_data", 32'(s_out_data), 32'(i));
            check("stream_valid", 32'(s_out_valid), 32'd1);
            check("stream_occ", 32'(s_occ), 32'd1);
            check("stream_ready", 32'(s_in_ready), 32'd1);
        end
        s_in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(s_out_valid), 32'd0);
        check("empty_keeps_last", 32'(s_out_data), 32'd4);

        // backpressure fill: A, B into skid, C waits upstream
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h000A;
        tick();
        s_in_data = 16'h000B;
        tick();
        check("bp_occ2", 32'(s_occ), 32'd2);
        check("bp_ready0", 32'(s_in_ready), 32'd0);
        s_in_data = 16'h000C;
        tick();
        check("bp_hold_A", 32'(s_out_data), 32'h000A);
        s_out_ready = 1'b1;
        tick();
        check("bp_out_B", 32'(s_out_data), 32'h000B);
        tick();
        check("bp_out_C", 32'(s_out_data), 32'h000C);
        s_in_valid = 1'b0;
        tick();
        check("bp_empty", 32'(s_out_valid), 32'd0);

        // stall while in SKID: nothing leaves, then two-cycle drain
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h0011;
        tick();
        s_in_data = 16'h0022;
        tick();
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        s_stall     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_data", 32'(s_out_data), 32'h0011);
            check("stall_ready", 32'(s_in_ready), 32'd0);
        end
        s_stall = 1'b0;
        tick();
        check("stall_drain1", 32'(s_out_data), 32'h0022);
        tick();
        check("stall_drain2", 32'(s_occ), 32'd0);

        // flush from SKID with 0x55 offered upstream
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h0033;
        tick();
        s_in_data = 16'h0044;
        tick();
        s_in_data = 16'h0055;
        s_flush   = 1'b1;
        tick();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        check("flush_valid", 32'(s_out_valid), 32'd0);
        check("flush_occ", 32'(s_occ), 32'd0);
        check("flush_data", 32'(s_out_data), 32'd0);
        check("flush_ready", 32'(s_in_ready), 32'd1);
        // flush from FULL while an in_fire really happens: it is dropped
        s_in_valid = 1'b1;
        s_in_data  = 16'h0060;
        tick();
        s_in_data = 16'h0066;
        s_flush   = 1'b1;
        tick();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        check("flush_drop_in", 32'(s_out_valid), 32'd0);
        tick();
        check("flush_drop_stays", 32'(s_out_data), 32'd0);

        // async reset while SKID is occupied
        s_in_valid = 1'b1;
        s_in_data  = 16'h0077;
        tick();
        s_in_data = 16'h0088;
        tick();
        s_in_valid = 1'b0;
        check("ar_pre_occ", 32'(s_occ), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(s_out_valid), 32'd0);
        check("ar_occ", 32'(s_occ), 32'd0);
        check("ar_data", 32'(s_out_data), 32'd0);
        check("ar_ready", 32'(s_in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #2;
        check("ar_ready_pre_edge", 32'(s_in_ready), 32'd0);
        tick();
        check("ar_ready_post_edge", 32'(s_in_ready), 32'd1);

        // legacy equivalence; an empty single-entry stage accepts even under
        // stall, which the valid-less legacy register cannot express, so the
        // cycle after a flush never stalls
        s_out_ready = 1'b0;
        l_flush = 1'b1;
        l_stall = 1'b0;
        tick();
        leg_en     = 1'b1;
        prev_flush = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            l_stall   = prev_flush ? 1'b0 : ($urandom_range(0, 3) == 0);
            l_flush   = ($urandom_range(0, 15) == 0);
            l_in_data = W'($urandom);
            prev_flush = l_flush;
            tick();
        end
        l_flush = 1'b0;
        l_stall = 1'b0;
        tick();
        leg_en = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
